seqgen: RTL and testbench



---
 rtl/seqgen.sv | 129 ++++++++++++
 tb/tb_seqgen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqgen.sv
// seqgen: parallel-load, MSB-first serial sequence generator with start/busy/done handshake.
// Optional SEQGEN_REPEAT_EN adds a repeat_i input that replays the captured pattern without a gap.
module seqgen #(
    parameter int WIDTH = 15,
    parameter int LEN_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
`ifdef SEQGEN_REPEAT_EN
    input  logic             repeat_i,
`endif
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [LEN_W-1:0]   cnt_q,   cnt_d;
    logic [LEN_W-1:0]   eff_m1;
`ifdef SEQGEN_REPEAT_EN
    logic [WIDTH-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]   rld_q,   rld_d;
`endif

    // Zero or oversize length means "send the whole register".
    always_comb begin
        if (len == '0 || len > WMAX) begin
            eff_m1 = WMAX - LEN_W'(1);
        end else begin
            eff_m1 = len - LEN_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SEQGEN_REPEAT_EN
            pat_q   <= '0;
            rld_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SEQGEN_REPEAT_EN
            pat_q   <= pat_d;
            rld_q   <= rld_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SEQGEN_REPEAT_EN
        pat_d   = pat_q;
        rld_d   = rld_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = data;
                    cnt_d   = eff_m1;
                    state_d = SHIFT;
`ifdef SEQGEN_REPEAT_EN
                    pat_d   = data;
                    rld_d   = eff_m1;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - LEN_W'(1);
                end else begin
`ifdef SEQGEN_REPEAT_EN
                    if (repeat_i) begin
                        shreg_d = pat_q;
                        cnt_d   = rld_q;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so reset clears them without waiting for an edge.
    always_comb begin
        x     = 1'b0;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            SHIFT: begin
                x     = shreg_q[WIDTH-1];
                valid = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                done  = 1'b1;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seqgen.sv
// Directed bench for seqgen: reset, full/short/clamped patterns, ignored start, back-to-back, mid-transfer reset.
module tb_seqgen;
    localparam int WIDTH = 15;
    localparam int LEN_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [LEN_W-1:0] len = '0;
`ifdef SEQGEN_REPEAT_EN
    logic             repeat_i = 1'b0;
`endif
    logic             x, valid, busy, done;

    int tests = 0;
    int fails = 0;

    seqgen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .data  (data),
        .len   (len),
`ifdef SEQGEN_REPEAT_EN
        .repeat_i (repeat_i),
`endif
        .x     (x),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic kick(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
        data  = d;
        len   = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            start = c[0] ? 1'b0 : 1'b1;
            data  = 15'h7FFF;
            len   = 4'd3;
            #1;
            tests++;
            if ({x, valid, busy, done} !== 4'b0000) begin
                $display("FAIL reset_hold%0d: x/valid/busy/done=%b required 0000", c, {x, valid, busy, done});
                fails++;
            end
            step();
        end
        start = 1'b0;
        RST   = 1'b1;
        step();
        step();
        tests++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            $display("FAIL reset_release: x/valid/busy/done=%b required 0000", {x, valid, busy, done});
            fails++;
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] pat;
        pat = 15'b010110101101100;
        kick(pat, 4'd15);
        for (int k = 0; k < 15; k++) begin
            tests++;
            if ({x, valid, busy, done} !== {pat[14-k], 3'b110}) begin
                $display("FAIL full_bit%0d: x/valid/busy/done=%b required %b", k, {x, valid, busy, done}, {pat[14-k], 3'b110});
                fails++;
            end
            step();
        end
        tests++;
        if ({x, valid, busy, done} !== 4'b0011) begin
            $display("FAIL full_done: x/valid/busy/done=%b required 0011", {x, valid, busy, done});
            fails++;
        end
        step();
        tests++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            $display("FAIL full_idle: x/valid/busy/done=%b required 0000", {x, valid, busy, done});
            fails++;
        end
    endtask

    task automatic test_short_clamp();
        logic [WIDTH-1:0] pat;
        logic [2:0]       exp3;
        pat  = 15'b101000000000000;
        exp3 = 3'b101;
        kick(pat, 4'd3);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({x, valid, busy, done} !== {exp3[2-k], 3'b110}) begin
                $display("FAIL short_bit%0d: x/valid/busy/done=%b required %b", k, {x, valid, busy, done}, {exp3[2-k], 3'b110});
                fails++;
            end
            step();
        end
        tests++;
        if ({x, valid, busy, done} !== 4'b0011) begin
            $display("FAIL short_done: x/valid/busy/done=%b required 0011", {x, valid, busy, done});
            fails++;
        end
        step();
        step();
        kick(pat, 4'd0);
        for (int k = 0; k < 15; k++) begin
            tests++;
            if ({x, valid, busy, done} !== {pat[14-k], 3'b110}) begin
                $display("FAIL clamp_bit%0d: x/valid/busy/done=%b required %b", k, {x, valid, busy, done}, {pat[14-k], 3'b110});
                fails++;
            end
            step();
        end
        tests++;
        if ({x, valid, busy, done} !== 4'b0011) begin
            $display("FAIL clamp_done: x/valid/busy/done=%b required 0011", {x, valid, busy, done});
            fails++;
        end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pat;
        pat = 15'b010110101101100;
        kick(pat, 4'd15);
        for (int k = 0; k < 15; k++) begin
            tests++;
            if ({x, valid, busy, done} !== {pat[14-k], 3'b110}) begin
                $display("FAIL ignored_bit%0d: x/valid/busy/done=%b required %b", k, {x, valid, busy, done}, {pat[14-k], 3'b110});
                fails++;
            end
            if (k == 4) begin
                start = 1'b1;
                data  = 15'h7FFF;
                len   = 4'd2;
            end
            step();
            start = 1'b0;
            data  = '0;
        end
        tests++;
        if ({x, valid, busy, done} !== 4'b0011) begin
            $display("FAIL ignored_done: x/valid/busy/done=%b required 0011", {x, valid, busy, done});
            fails++;
        end
        start = 1'b1;
        data  = 15'h7FFF;
        len   = 4'd2;
        step();
        tests++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            $display("FAIL b2b_idle_gap: x/valid/busy/done=%b required 0000", {x, valid, busy, done});
            fails++;
        end
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({x, valid, busy, done} !== 4'b1110) begin
                $display("FAIL b2b_bit%0d: x/valid/busy/done=%b required 1110", k, {x, valid, busy, done});
                fails++;
            end
            step();
        end
        tests++;
        if ({x, valid, busy, done} !== 4'b0011) begin
            $display("FAIL b2b_done: x/valid/busy/done=%b required 0011", {x, valid, busy, done});
            fails++;
        end
        step();
        step();
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] pat;
        pat = 15'b010110101101100;
        kick(pat, 4'd15);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({x, valid, busy, done} !== {pat[14-k], 3'b110}) begin
                $display("FAIL midrst_pre%0d: x/valid/busy/done=%b required %b", k, {x, valid, busy, done}, {pat[14-k], 3'b110});
                fails++;
            end
            if (k < 4) step();
        end
        #2 RST = 1'b0;
        #1;
        tests++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            $display("FAIL midrst_async: x/valid/busy/done=%b required 0000", {x, valid, busy, done});
            fails++;
        end
        step();
        step();
        RST = 1'b1;
        step();
        kick(pat, 4'd15);
        for (int k = 0; k < 15; k++) begin
            tests++;
            if ({x, valid, busy, done} !== {pat[14-k], 3'b110}) begin
                $display("FAIL midrst_post%0d: x/valid/busy/done=%b required %b", k, {x, valid, busy, done}, {pat[14-k], 3'b110});
                fails++;
            end
            step();
        end
        tests++;
        if ({x, valid, busy, done} !== 4'b0011) begin
            $display("FAIL midrst_done: x/valid/busy/done=%b required 0011", {x, valid, busy, done});
            fails++;
        end
        step();
        step();
    endtask

`ifdef SEQGEN_REPEAT_EN
    task automatic test_repeat();
        logic [3:0] exp4;
        exp4     = 4'b1101;
        repeat_i = 1'b1;
        kick(15'b110100000000000, 4'd4);
        for (int i = 0; i < 12; i++) begin
            tests++;
            if ({x, valid, busy, done} !== {exp4[3 - (i % 4)], 3'b110}) begin
                $display("FAIL repeat_bit%0d: x/valid/busy/done=%b required %b", i, {x, valid, busy, done}, {exp4[3 - (i % 4)], 3'b110});
                fails++;
            end
            if (i == 8) repeat_i = 1'b0;
            step();
        end
        tests++;
        if ({x, valid, busy, done} !== 4'b0011) begin
            $display("FAIL repeat_done: x/valid/busy/done=%b required 0011", {x, valid, busy, done});
            fails++;
        end
        step();
        tests++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            $display("FAIL repeat_idle: x/valid/busy/done=%b required 0000", {x, valid, busy, done});
            fails++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_short_clamp();
        test_back_to_back();
        test_mid_reset();
`ifdef SEQGEN_REPEAT_EN
        test_repeat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
